// File: rtl/resize_pkg.sv
// Shared types for the resize sequencer: FSM states, display source selection
// and the engine mode numbering used by the image coprocessor.
package resize_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_LAUNCH = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SHOW_NONE     = 2'd0,
    SHOW_ORIGINAL = 2'd1,
    SHOW_RESULT   = 2'd2
  } show_t;

  localparam int REPLICACAO      = 0;
  localparam int DECIMACAO       = 1;
  localparam int VIZINHO_PROXIMO = 2;
  localparam int MEDIA_BLOCOS    = 3;

endpackage

// File: rtl/resize_disp_addr.sv
// Display-side addressing: maps the next VGA pixel into the centred image window,
// produces ROM/RAM read addresses and the registered display source select.
module resize_disp_addr
  import resize_pkg::*;
#(
  parameter int SRC_W  = 160,
  parameter int ROM_AW = 15,
  parameter int RAM_AW = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic [9:0]        x_off,
  input  logic [9:0]        y_off,
  input  logic [9:0]        img_w,
  input  logic [9:0]        img_h,
  input  show_t             show,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [1:0]        disp_sel
);

  logic [9:0]        dx_s;
  logic [9:0]        dy_s;
  logic [10:0]       x_end_s;
  logic [10:0]       y_end_s;
  logic              in_bounds_s;
  logic [RAM_AW-1:0] ram_lin_s;
  logic [RAM_AW-1:0] rom_lin_s;
  logic [1:0]        disp_sel_r;

  // window-relative coordinates, bounds test and linear addresses
  always_comb begin
    dx_s        = pix_x - x_off;
    dy_s        = pix_y - y_off;
    x_end_s     = {1'b0, x_off} + {1'b0, img_w};
    y_end_s     = {1'b0, y_off} + {1'b0, img_h};
    in_bounds_s = (pix_x >= x_off) && ({1'b0, pix_x} < x_end_s) &&
                  (pix_y >= y_off) && ({1'b0, pix_y} < y_end_s);
    ram_lin_s   = RAM_AW'(dy_s) * RAM_AW'(img_w) + RAM_AW'(dx_s);
    rom_lin_s   = RAM_AW'(dy_s) * RAM_AW'(SRC_W) + RAM_AW'(dx_s);
  end

  assign ram_addr = ram_lin_s;
  assign rom_addr = ROM_AW'(rom_lin_s);

  // one-cycle delay so the select lines up with the memory read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_sel_r <= 2'b00;
    end else if (in_bounds_s) begin
      disp_sel_r <= {show == SHOW_RESULT, show == SHOW_ORIGINAL};
    end else begin
      disp_sel_r <= 2'b00;
    end
  end

  assign disp_sel = disp_sel_r;

endmodule

// File: rtl/resize_sequencer.sv
// Control core of the image coprocessor: validates a resize command, launches one
// engine, lends it the memory ports under a watchdog, and centres the displayed image.
module resize_sequencer
  import resize_pkg::*;
#(
  parameter int SRC_W       = 160,
  parameter int SRC_H       = 120,
  parameter int FRAME_W     = 640,
  parameter int FRAME_H     = 480,
  parameter int PIX_W       = 8,
  parameter int NUM_ALGOS   = 4,
  parameter logic [NUM_ALGOS-1:0] ZOOM_IN_MASK = NUM_ALGOS'(4'b0101),
  parameter int MAX_LOG2    = 3,
  parameter int ROM_AW      = 15,
  parameter int RAM_AW      = 19,
  parameter int TIMEOUT_CYC = 2**21,
  parameter int MW          = (NUM_ALGOS > 1) ? $clog2(NUM_ALGOS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_n,
  input  logic                        abort,
  input  logic [MW-1:0]               mode,
  input  logic [1:0]                  zoom,
  output logic [NUM_ALGOS-1:0]        eng_start,
  input  logic [NUM_ALGOS-1:0]        eng_done,
  input  logic [NUM_ALGOS*ROM_AW-1:0] eng_rom_addr,
  input  logic [NUM_ALGOS*RAM_AW-1:0] eng_wr_addr,
  input  logic [NUM_ALGOS*PIX_W-1:0]  eng_wr_data,
  input  logic [NUM_ALGOS-1:0]        eng_wren,
  input  logic [9:0]                  pix_x,
  input  logic [9:0]                  pix_y,
  output logic [ROM_AW-1:0]           rom_addr,
  output logic [RAM_AW-1:0]           ram_addr,
  output logic [PIX_W-1:0]            ram_data,
  output logic                        ram_wren,
  output logic [1:0]                  disp_sel,
  output logic                        busy,
  output logic                        ready,
  output logic                        error
);

  localparam int         WD_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [9:0] SRC_W_D    = 10'(SRC_W);
  localparam logic [9:0] SRC_H_D    = 10'(SRC_H);
  localparam logic [9:0] ORIG_X_OFF = 10'((FRAME_W - SRC_W) / 2);
  localparam logic [9:0] ORIG_Y_OFF = 10'((FRAME_H - SRC_H) / 2);

  state_t                state_r;
  show_t                 show_r;
  logic                  start_n_r;
  logic [MW-1:0]         mode_r;
  logic [1:0]            zoom_r;
  logic [9:0]            img_w_r, img_h_r, x_off_r, y_off_r;
  logic [WD_W-1:0]       wd_r;
  logic [NUM_ALGOS-1:0]  eng_start_r;
  logic                  busy_r, ready_r, error_r;

  logic                  start_fall_s;
  logic                  enlarge_s;
  logic                  valid_s;
  logic [31:0]           nw_s, nh_s, area_s;
  logic [ROM_AW-1:0]     disp_rom_s;
  logic [RAM_AW-1:0]     disp_ram_s;

  assign start_fall_s = start_n_r & ~start_n;

  // candidate dimensions and legality of the latched command
  always_comb begin
    enlarge_s = 1'b0;
    if (32'(mode_r) < 32'(NUM_ALGOS)) begin
      enlarge_s = ZOOM_IN_MASK[mode_r];
    end else begin
      enlarge_s = 1'b0;
    end
    if (enlarge_s) begin
      nw_s = 32'(SRC_W) << zoom_r;
      nh_s = 32'(SRC_H) << zoom_r;
    end else begin
      nw_s = 32'(SRC_W) >> zoom_r;
      nh_s = 32'(SRC_H) >> zoom_r;
    end
    area_s  = nw_s * nh_s;
    valid_s = (32'(zoom_r) <= 32'(MAX_LOG2)) && (32'(mode_r) < 32'(NUM_ALGOS)) &&
              (nw_s <= 32'(FRAME_W)) && (nh_s <= 32'(FRAME_H)) &&
              (nw_s != 32'd0) && (nh_s != 32'd0) && (area_s <= (32'd1 << RAM_AW));
  end

  // command FSM, watchdog and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      start_n_r   <= 1'b1;
      mode_r      <= {MW{1'b0}};
      zoom_r      <= 2'd0;
      show_r      <= SHOW_ORIGINAL;
      img_w_r     <= SRC_W_D;
      img_h_r     <= SRC_H_D;
      x_off_r     <= ORIG_X_OFF;
      y_off_r     <= ORIG_Y_OFF;
      wd_r        <= {WD_W{1'b0}};
      eng_start_r <= {NUM_ALGOS{1'b0}};
      busy_r      <= 1'b0;
      ready_r     <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      start_n_r   <= start_n;
      eng_start_r <= {NUM_ALGOS{1'b0}};
      ready_r     <= 1'b0;
      case (state_r)
        S_IDLE, S_ERROR: begin
          if (start_fall_s) begin
            state_r <= S_CHECK;
            mode_r  <= mode;
            zoom_r  <= zoom;
            show_r  <= SHOW_NONE;
            busy_r  <= 1'b1;
            error_r <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        S_CHECK: begin
          if (valid_s) begin
            state_r     <= S_LAUNCH;
            img_w_r     <= 10'(nw_s);
            img_h_r     <= 10'(nh_s);
            x_off_r     <= 10'((32'(FRAME_W) - nw_s) >> 1);
            y_off_r     <= 10'((32'(FRAME_H) - nh_s) >> 1);
            eng_start_r <= NUM_ALGOS'(1) << mode_r;
          end else begin
            state_r <= S_ERROR;
            busy_r  <= 1'b0;
            error_r <= 1'b1;
          end
        end
        S_LAUNCH: begin
          state_r <= S_RUN;
          wd_r    <= {WD_W{1'b0}};
        end
        S_RUN: begin
          // abort wins over a done arriving in the same cycle
          if (abort) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            show_r  <= SHOW_ORIGINAL;
            img_w_r <= SRC_W_D;
            img_h_r <= SRC_H_D;
            x_off_r <= ORIG_X_OFF;
            y_off_r <= ORIG_Y_OFF;
          end else if (eng_done[mode_r]) begin
            state_r <= S_DONE;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
            show_r  <= SHOW_RESULT;
          end else if (wd_r == WD_LAST) begin
            state_r <= S_ERROR;
            busy_r  <= 1'b0;
            error_r <= 1'b1;
            show_r  <= SHOW_NONE;
          end else begin
            wd_r <= wd_r + WD_W'(1);
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  resize_disp_addr #(
    .SRC_W  (SRC_W),
    .ROM_AW (ROM_AW),
    .RAM_AW (RAM_AW)
  ) u_disp_addr (
    .clk      (clk),
    .reset    (reset),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .x_off    (x_off_r),
    .y_off    (y_off_r),
    .img_w    (img_w_r),
    .img_h    (img_h_r),
    .show     (show_r),
    .rom_addr (disp_rom_s),
    .ram_addr (disp_ram_s),
    .disp_sel (disp_sel)
  );

  // memory port ownership: running engine passes straight through, display otherwise
  always_comb begin
    if (state_r == S_RUN) begin
      rom_addr = eng_rom_addr[int'(mode_r)*ROM_AW +: ROM_AW];
      ram_addr = eng_wr_addr[int'(mode_r)*RAM_AW +: RAM_AW];
      ram_data = eng_wr_data[int'(mode_r)*PIX_W +: PIX_W];
      ram_wren = eng_wren[mode_r];
    end else begin
      rom_addr = disp_rom_s;
      ram_addr = disp_ram_s;
      ram_data = {PIX_W{1'b0}};
      ram_wren = 1'b0;
    end
  end

  assign eng_start = eng_start_r;
  assign busy      = busy_r;
  assign ready     = ready_r;
  assign error     = error_r;

endmodule
